spi_apb_xfer_master: RTL and testbench
======================================

# spi_apb_xfer_master

APB master sequencer that sits directly upstream of the APB-attached SPI master and drives its bus port. After reset it programs CR1, CR2 and BR once. For each byte accepted on a valid/ready command stream, it writes SPI_DR, polls the status register for transfer complete, reads SPI_DR back and returns the received byte on a valid/ready response stream. One transfer is outstanding at a time.

## Interface
- CR1_VAL, 8'h5C: value written to CR1 (addr 3'b000) during configuration.
- CR2_VAL, 8'h00: value written to CR2 (addr 3'b001).
- BR_VAL, 8'h00: value written to BR (addr 3'b010).
- POLL_LIMIT, 16: maximum number of SR reads per transfer before timeout (≥1).
- PCLK  in  1  single clock; all logic on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command byte available.
- cmd_data  in  8  byte to transmit on MOSI.
- cmd_ready  out  1  sequencer accepts cmd_data this cycle.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_data  out  8  byte received from MISO (8'h00 on error).
- rsp_err  out  1  response qualifier: PSLVERR or poll timeout occurred.
- cfg_done  out  1  configuration completed without error.
- cfg_fault  out  1  PSLVERR during configuration; sticky until reset.
- busy  out  1  high in any state except WAIT_CMD and FAULT.
- PADDR  out  3  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- PREADY  in  1  APB ready; inserts wait states.
- PSLVERR  in  1  APB error, sampled with PREADY.

## Operation
- Register map:
  - CR1 = 3'b000, CR2 = 3'b001, BR = 3'b010.
  - SR = 3'b011; bit 7 is SPIF.
  - SPI_DR = 3'b101.
- Top FSM states:
  - CFG1, CFG2, CFG3: write CR1, CR2, BR in that order. CFG1 is entered on the first cycle after reset release.
  - WAIT_CMD: cmd_ready=1. A cmd_valid&cmd_ready handshake captures cmd_data and moves to TX.
  - TX: write cmd_data to SPI_DR.
  - POLL: read SR. SPIF=1 → RX. SPIF=0 → increment the poll counter and read SR again. Counter reaching POLL_LIMIT → RSP with rsp_err=1.
  - RX: read SPI_DR and capture PRDATA into rsp_data.
  - RSP: rsp_valid=1. Leave on rsp_valid&rsp_ready and go to WAIT_CMD.
  - FAULT: terminal. cmd_ready=0, busy=0. Exits only on reset.
- APB sub-phases within each bus state:
  - SETUP: PSEL=1, PENABLE=0, address and data valid.
  - ACCESS: PSEL=1, PENABLE=1. Held until PREADY=1.
  - IDLE: exactly one cycle with PSEL=0, PENABLE=0 between consecutive transactions.
- PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle.
- PSLVERR is sampled only on the cycle where PREADY=1 in ACCESS.
  - During CFG states: set cfg_fault and go to FAULT.
  - During TX, POLL or RX: go to RSP with rsp_err=1 and rsp_data=8'h00. No further bus transactions for that command.
- cfg_done sets on successful BR completion and remains 1 until reset.
- The poll counter clears on entry to TX. It is 16 bits wide and saturates; it does not wrap.
- cmd_valid is ignored outside WAIT_CMD. A command presented during CFG waits; it is not dropped.

## Timing
- Reset values:
  - PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, cfg_done, cfg_fault = 0.
  - PADDR = 3'b000, PWDATA = 8'h00, rsp_data = 8'h00.
  - busy = 1 (CFG1 pending).
- APB transaction with zero wait states: 2 cycles (SETUP, ACCESS) plus 1 IDLE cycle. Each PREADY-low cycle adds 1.
- Configuration with zero wait states takes 9 cycles. cfg_done rises the cycle after the third ACCESS completes, and cmd_ready rises in that same cycle.
- Command-to-response latency (zero wait states, SPIF on the k-th SR read): 3 + 3k + 3 cycles from the cmd handshake to the rsp_valid rise.
- rsp_valid, rsp_data and rsp_err are registered and stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-transaction:
  - PSEL and PENABLE drop asynchronously.
  - All state is lost and the configuration sequence reruns after release.
  - No pending response survives reset.

## Test plan
- Reset then release, PREADY tied high → writes 5C@0, 00@1, 00@2, each SETUP/ACCESS/IDLE. cfg_done=1 on cycle 9, cmd_ready=1.
- cmd 8'hB9, SPIF on the 3rd SR read, DR read returns 8'h65 → write B9@5, three reads @3, one read @5. rsp_data=8'h65, rsp_err=0, latency 15 cycles.
- Same transfer with PREADY low for 2 cycles on every ACCESS → PADDR, PWDATA and PWRITE stable throughout. Latency increases by exactly 2 per transaction.
- SPIF never set with POLL_LIMIT=4 → exactly 4 SR reads, then rsp_err=1 and rsp_data=00. The next command proceeds normally.
- PSLVERR on the DR write → no SR reads occur, rsp_err=1. PSLVERR on the CR2 write → cfg_fault=1, no BR write, cmd_ready stays 0.
- rsp_ready held low for 10 cycles, then PRESETn pulsed mid-poll on the next command → response held stable until the handshake. After reset the APB outputs are 0 immediately and configuration reruns.

Source files
------------

// File: rtl/spi_apb_xfer_master.sv
// APB master sequencer for the APB-attached SPI master: programs CR1/CR2/BR once
// after reset, then runs one write-DR / poll-SR / read-DR exchange per command byte.
module spi_apb_xfer_master #(
    parameter logic [7:0]  CR1_VAL    = 8'h5C,
    parameter logic [7:0]  CR2_VAL    = 8'h00,
    parameter logic [7:0]  BR_VAL     = 8'h00,
    parameter int unsigned POLL_LIMIT = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic       cfg_done,
    output logic       cfg_fault,
    output logic       busy,
    output logic [2:0] PADDR,
    output logic       PWRITE,
    output logic       PSEL,
    output logic       PENABLE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    typedef enum logic [3:0] {
        ST_CFG1, ST_CFG2, ST_CFG3, ST_WAIT_CMD, ST_TX, ST_POLL, ST_RX, ST_RSP, ST_FAULT
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    localparam logic [2:0]  ADDR_CR1     = 3'b000;
    localparam logic [2:0]  ADDR_CR2     = 3'b001;
    localparam logic [2:0]  ADDR_BR      = 3'b010;
    localparam logic [2:0]  ADDR_SR      = 3'b011;
    localparam logic [2:0]  ADDR_DR      = 3'b101;
    localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [2:0]  paddr_q, paddr_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_fault_q, cfg_fault_d;
    logic        busy_q, busy_d;

    logic       bus_state;
    logic [2:0] bus_addr;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic       xfer_done;
    logic       rsp_fail;

    // Which APB transaction the current state issues, if any.
    always_comb begin
        bus_state = 1'b1;
        bus_addr  = ADDR_CR1;
        bus_write = 1'b1;
        bus_wdata = CR1_VAL;
        case (state_q)
            ST_CFG1: ;
            ST_CFG2: begin bus_addr = ADDR_CR2; bus_wdata = CR2_VAL;    end
            ST_CFG3: begin bus_addr = ADDR_BR;  bus_wdata = BR_VAL;     end
            ST_TX:   begin bus_addr = ADDR_DR;  bus_wdata = cmd_byte_q; end
            ST_POLL: begin bus_addr = ADDR_SR;  bus_write = 1'b0; bus_wdata = 8'h00; end
            ST_RX:   begin bus_addr = ADDR_DR;  bus_write = 1'b0; bus_wdata = 8'h00; end
            default: begin bus_state = 1'b0;    bus_write = 1'b0; bus_wdata = 8'h00; end
        endcase
    end

    assign xfer_done = bus_state && (phase_q == PH_ACCESS) && PREADY;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        cmd_byte_d  = cmd_byte_q;
        poll_cnt_d  = poll_cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cfg_done_d  = cfg_done_q;
        cfg_fault_d = cfg_fault_q;
        busy_d      = busy_q;
        rsp_fail    = 1'b0;

        // Every bus state opens with one idle cycle, which gives the mandatory gap.
        if (bus_state) begin
            case (phase_q)
                PH_IDLE: begin
                    phase_d  = PH_SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = bus_addr;
                    pwrite_d = bus_write;
                    pwdata_d = bus_wdata;
                end
                PH_SETUP: begin
                    phase_d   = PH_ACCESS;
                    penable_d = 1'b1;
                end
                default: begin
                    if (PREADY) begin
                        phase_d   = PH_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
            endcase
        end

        case (state_q)
            ST_CFG1, ST_CFG2, ST_CFG3: begin
                if (xfer_done) begin
                    if (PSLVERR) begin
                        state_d     = ST_FAULT;
                        cfg_fault_d = 1'b1;
                        busy_d      = 1'b0;
                    end else if (state_q == ST_CFG3) begin
                        state_d     = ST_WAIT_CMD;
                        cfg_done_d  = 1'b1;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = (state_q == ST_CFG1) ? ST_CFG2 : ST_CFG3;
                    end
                end
            end
            ST_WAIT_CMD: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_TX;
                    cmd_byte_d  = cmd_data;
                    poll_cnt_d  = 16'd0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_TX: begin
                if (xfer_done) begin
                    if (PSLVERR) rsp_fail = 1'b1;
                    else         state_d  = ST_POLL;
                end
            end
            ST_POLL: begin
                if (xfer_done) begin
                    if (PSLVERR) begin
                        rsp_fail = 1'b1;
                    end else if (PRDATA[7]) begin
                        state_d = ST_RX;
                    end else begin
                        poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
                        if (poll_cnt_d >= POLL_LIMIT_W) rsp_fail = 1'b1;
                    end
                end
            end
            ST_RX: begin
                if (xfer_done) begin
                    if (PSLVERR) begin
                        rsp_fail = 1'b1;
                    end else begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = PRDATA;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_WAIT_CMD;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase

        // Bus error or poll timeout abandons the command with an error response.
        if (rsp_fail) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_err_d   = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_CFG1;
            phase_q     <= PH_IDLE;
            cmd_byte_q  <= 8'h00;
            poll_cnt_q  <= 16'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 3'b000;
            pwdata_q    <= 8'h00;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_fault_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_byte_q  <= cmd_byte_d;
            poll_cnt_q  <= poll_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cfg_done_q  <= cfg_done_d;
            cfg_fault_q <= cfg_fault_d;
            busy_q      <= busy_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_fault = cfg_fault_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_apb_xfer_master.sv
// Directed bench for spi_apb_xfer_master: an APB slave model logs every transaction,
// and expected transactions/responses are queued by the stimulus and compared as they arrive.
module tb_spi_apb_xfer_master;

    localparam int LIMIT = 4;

    logic       PCLK      = 1'b0;
    logic       PRESETn   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data  = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_ready = 1'b1;
    logic       cfg_done, cfg_fault, busy;
    logic [2:0] PADDR;
    logic       PWRITE, PSEL, PENABLE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA  = 8'h00;
    logic       PREADY  = 1'b1;
    logic       PSLVERR = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Slave model knobs (written by the stimulus) and slave bookkeeping.
    int         wait_states = 0;
    int         spif_at     = 0;
    logic [7:0] rx_byte     = 8'h00;
    logic       err_en      = 1'b0;
    logic [2:0] err_addr    = 3'd0;
    logic       err_wr      = 1'b0;
    int         sr_cnt      = 0;
    int         wait_cnt    = 0;
    int         stab_viol   = 0;
    logic [2:0] cap_addr    = 3'd0;
    logic       cap_write   = 1'b0;
    logic [7:0] cap_wdata   = 8'h00;

    logic [11:0] exp_txn[$];
    logic [11:0] obs_txn[$];
    logic [8:0]  exp_rsp[$];

    spi_apb_xfer_master #(
        .CR1_VAL   (8'h5C),
        .CR2_VAL   (8'h00),
        .BR_VAL    (8'h00),
        .POLL_LIMIT(LIMIT)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .rsp_ready(rsp_ready),
        .cfg_done (cfg_done),
        .cfg_fault(cfg_fault),
        .busy     (busy),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // APB slave: answers on the falling edge, SR bit 7 set on the spif_at-th read after a DR write.
    always @(negedge PCLK) begin
        if (PSEL && !PENABLE) begin
            cap_addr  = PADDR;
            cap_write = PWRITE;
            cap_wdata = PWDATA;
            wait_cnt  = 0;
            PREADY    = (wait_states == 0);
            PSLVERR   = 1'b0;
        end else if (PSEL && PENABLE) begin
            if (PADDR !== cap_addr || PWRITE !== cap_write || PWDATA !== cap_wdata)
                stab_viol++;
            if (wait_cnt < wait_states) begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                wait_cnt++;
            end else begin
                PREADY  = 1'b1;
                obs_txn.push_back({PWRITE, PADDR, PWRITE ? PWDATA : 8'h00});
                PSLVERR = err_en && (PADDR == err_addr) && (PWRITE == err_wr);
                PRDATA  = 8'h00;
                if (PWRITE && PADDR == 3'd5) begin
                    sr_cnt = 0;
                end else if (!PWRITE && PADDR == 3'd3) begin
                    sr_cnt++;
                    PRDATA = (spif_at != 0 && sr_cnt == spif_at) ? 8'hA5 : 8'h7F;
                end else if (!PWRITE && PADDR == 3'd5) begin
                    PRDATA = rx_byte;
                end
            end
        end else begin
            PREADY  = (wait_states == 0);
            PSLVERR = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
        #1;
    endtask

    function automatic logic [11:0] wr(input logic [2:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [11:0] rd(input logic [2:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    // Zero-wait latency from handshake to rsp_valid is 3 + 3k + 3; each wait state adds one.
    function automatic int exp_lat(input int k, input int waits);
        return 3 + 3 * k + 3 + waits * (k + 2);
    endfunction

    task automatic push_cfg();
        exp_txn.push_back(wr(3'd0, 8'h5C));
        exp_txn.push_back(wr(3'd1, 8'h00));
        exp_txn.push_back(wr(3'd2, 8'h00));
    endtask

    task automatic push_xfer(input logic [7:0] tx, input int reads, input bit do_rx);
        exp_txn.push_back(wr(3'd5, tx));
        repeat (reads) exp_txn.push_back(rd(3'd3));
        if (do_rx) exp_txn.push_back(rd(3'd5));
    endtask

    task automatic send_cmd(input logic [7:0] d, output int hs);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("cmd_accept", 16'(cmd_ready), 16'd1);
        step();
        hs        = cyc;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic wait_rsp(input string tag, input int hs, input int lat, input int hold);
        int n = 0;
        logic [8:0] e;
        while (rsp_valid !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        check({tag, "_rsp_seen"}, 16'(rsp_valid), 16'd1);
        e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 9'h1FF;
        check({tag, "_latency"}, 16'(cyc - hs), 16'(lat));
        check({tag, "_rsp_data"}, 16'(rsp_data), 16'(e[7:0]));
        check({tag, "_rsp_err"}, 16'(rsp_err), 16'(e[8]));
        repeat (hold) begin
            step();
            check({tag, "_hold_valid"}, 16'(rsp_valid), 16'd1);
            check({tag, "_hold_data"}, 16'(rsp_data), 16'(e[7:0]));
            check({tag, "_hold_err"}, 16'(rsp_err), 16'(e[8]));
        end
        rsp_ready = 1'b1;
        step();
        check({tag, "_rsp_drop"}, 16'(rsp_valid), 16'd0);
        check({tag, "_ready_back"}, 16'(cmd_ready), 16'd1);
    endtask

    task automatic drain(input string tag);
        check({tag, "_txn_count"}, 16'(obs_txn.size()), 16'(exp_txn.size()));
        while (obs_txn.size() > 0 && exp_txn.size() > 0)
            check({tag, "_txn"}, 16'(obs_txn.pop_front()), 16'(exp_txn.pop_front()));
        obs_txn.delete();
        exp_txn.delete();
        check({tag, "_apb_stable"}, 16'(stab_viol), 16'd0);
    endtask

    initial begin
        int c0;
        int hs;
        int n;

        // Reset state.
        step();
        step();
        check("rst_psel", 16'(PSEL), 16'd0);
        check("rst_penable", 16'(PENABLE), 16'd0);
        check("rst_pwrite", 16'(PWRITE), 16'd0);
        check("rst_paddr", 16'(PADDR), 16'd0);
        check("rst_pwdata", 16'(PWDATA), 16'd0);
        check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
        check("rst_rsp", 16'({rsp_valid, rsp_err, rsp_data}), 16'd0);
        check("rst_cfg", 16'({cfg_done, cfg_fault}), 16'd0);
        check("rst_busy", 16'(busy), 16'd1);

        // Configuration with a command already waiting, then SPIF on the 3rd SR read.
        push_cfg();
        push_xfer(8'hB9, 3, 1'b1);
        exp_rsp.push_back({1'b0, 8'h65});
        spif_at   = 3;
        rx_byte   = 8'h65;
        cmd_valid = 1'b1;
        cmd_data  = 8'hB9;
        PRESETn   = 1'b1;
        c0        = cyc;
        repeat (8) begin
            step();
            check("cfg_cmd_held", 16'(cmd_ready), 16'd0);
        end
        check("cfg_done_c8", 16'(cfg_done), 16'd0);
        step();
        check("cfg_done_c9", 16'(cfg_done), 16'd1);
        check("cmd_ready_c9", 16'(cmd_ready), 16'd1);
        check("busy_wait_cmd", 16'(busy), 16'd0);
        send_cmd(8'hB9, hs);
        check("t1_hs_cycle", 16'(hs - c0), 16'd10);
        wait_rsp("t1", hs, exp_lat(3, 0), 0);
        drain("t1");

        // Same transfer with two wait states on every ACCESS.
        wait_states = 2;
        push_xfer(8'hB9, 3, 1'b1);
        exp_rsp.push_back({1'b0, 8'h65});
        send_cmd(8'hB9, hs);
        wait_rsp("t2", hs, exp_lat(3, 2), 0);
        drain("t2");
        wait_states = 0;

        // SPIF never set: exactly LIMIT SR reads, no DR read, 3 + 3*LIMIT cycles.
        spif_at = 0;
        rx_byte = 8'h77;
        push_xfer(8'h3C, LIMIT, 1'b0);
        exp_rsp.push_back({1'b1, 8'h00});
        send_cmd(8'h3C, hs);
        wait_rsp("t3", hs, 3 + 3 * LIMIT, 0);
        drain("t3");

        // Following command proceeds normally.
        spif_at = 1;
        rx_byte = 8'h5A;
        push_xfer(8'hC3, 1, 1'b1);
        exp_rsp.push_back({1'b0, 8'h5A});
        send_cmd(8'hC3, hs);
        wait_rsp("t3b", hs, exp_lat(1, 0), 0);
        drain("t3b");

        // PSLVERR on the DR write: no SR reads, error response right after the write.
        err_en   = 1'b1;
        err_addr = 3'd5;
        err_wr   = 1'b1;
        push_xfer(8'h11, 0, 1'b0);
        exp_rsp.push_back({1'b1, 8'h00});
        send_cmd(8'h11, hs);
        wait_rsp("t4", hs, 3, 0);
        drain("t4");
        err_en = 1'b0;

        // Response held for 10 cycles with rsp_ready low.
        rsp_ready = 1'b0;
        spif_at   = 2;
        rx_byte   = 8'hE1;
        push_xfer(8'h96, 2, 1'b1);
        exp_rsp.push_back({1'b0, 8'hE1});
        send_cmd(8'h96, hs);
        wait_rsp("t5", hs, exp_lat(2, 0), 10);
        drain("t5");

        // Reset pulsed during the second SR read of the next command.
        spif_at = 0;
        push_xfer(8'h42, 2, 1'b0);
        send_cmd(8'h42, hs);
        n = 0;
        while (!(sr_cnt == 2 && PSEL && PENABLE && PREADY) && n < 200) begin
            step();
            n++;
        end
        check("t6_reach_poll", 16'(sr_cnt), 16'd2);
        PRESETn = 1'b0;
        #1;
        check("t6_async_psel", 16'(PSEL), 16'd0);
        check("t6_async_penable", 16'(PENABLE), 16'd0);
        step();
        check("t6_no_rsp", 16'(rsp_valid), 16'd0);
        check("t6_busy", 16'(busy), 16'd1);
        check("t6_cfg_cleared", 16'({cfg_done, cmd_ready}), 16'd0);
        drain("t6");
        push_cfg();
        PRESETn = 1'b1;
        repeat (9) step();
        check("t6_cfg_rerun", 16'(cfg_done), 16'd1);
        check("t6_cmd_ready", 16'(cmd_ready), 16'd1);
        check("t6_rsp_idle", 16'(rsp_valid), 16'd0);
        drain("t6_cfg");

        // PSLVERR on the CR2 write: sticky fault, BR never written, commands refused.
        PRESETn = 1'b0;
        step();
        err_en   = 1'b1;
        err_addr = 3'd1;
        err_wr   = 1'b1;
        exp_txn.push_back(wr(3'd0, 8'h5C));
        exp_txn.push_back(wr(3'd1, 8'h00));
        cmd_valid = 1'b1;
        cmd_data  = 8'h24;
        PRESETn   = 1'b1;
        repeat (20) begin
            step();
            check("t7_cmd_refused", 16'(cmd_ready), 16'd0);
        end
        check("t7_cfg_fault", 16'(cfg_fault), 16'd1);
        check("t7_cfg_done", 16'(cfg_done), 16'd0);
        check("t7_busy", 16'(busy), 16'd0);
        check("t7_bus_idle", 16'({PSEL, PENABLE}), 16'd0);
        drain("t7");
        cmd_valid = 1'b0;
        err_en    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
